// File: rtl/soc_mmio_pkg.sv
// Shared MMIO map for the small SoC: register addresses, UART status bit
// positions and the UART TX controller state encoding.
package soc_mmio_pkg;

    localparam logic [10:0] LED_ADDR       = 11'd100;
    localparam logic [10:0] UART_DATA_ADDR = 11'd101;
    localparam logic [10:0] UART_STAT_ADDR = 11'd102;

    // Status byte layout: {count[3:0], overflow, timeout_err, tx_active, full}
    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_ACTIVE_BIT = 1;
    localparam int STAT_TOERR_BIT  = 2;
    localparam int STAT_OVF_BIT    = 3;
    localparam int STAT_CNT_LSB    = 4;

    // Control write to the status address: bit0 flushes the TX FIFO.
    localparam int CTRL_FLUSH_BIT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LAUNCH     = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with occupancy count and synchronous flush.
// A push to a full FIFO is taken only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign dout    = mem[rd_ptr_q];
    assign count   = count_q;

    // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_push && !do_pop) count_d = count_q + CW'(1);
            if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// MMIO front end for a UART transmitter: CPU writes bytes into a TX FIFO and
// an FSM feeds them one at a time to the transmitter.
module uart_tx_ctrl
    import soc_mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [10:0] DATA_ADDR     = UART_DATA_ADDR,
    parameter logic [10:0] STAT_ADDR     = UART_STAT_ADDR,
    parameter int          START_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [10:0] m_addr,
    input  logic [7:0]  m_wr_data,
    input  logic        m_wr,
    input  logic        m_rd,
    input  logic        m_en,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic [7:0]  tx_din,
    output logic        tx_wr_en,
    input  logic        tx_busy,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(START_TIMEOUT - 1);

    uart_tx_state_e state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [7:0]     tx_din_q, tx_din_d;
    logic           ovf_q, ovf_d;
    logic           toerr_q, toerr_d;
    logic           to_set;

    logic           data_wr, stat_wr, data_rd, stat_rd, flush;
    logic           pop_req, ovf_set;
    logic [7:0]     fifo_dout;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [4:0]     count_ext;
    logic [7:0]     status, free_cnt;

    assign data_wr = m_en & m_wr & (m_addr == DATA_ADDR);
    assign stat_wr = m_en & m_wr & (m_addr == STAT_ADDR);
    assign data_rd = m_en & m_rd & (m_addr == DATA_ADDR);
    assign stat_rd = m_en & m_rd & (m_addr == STAT_ADDR);
    assign flush   = stat_wr & m_wr_data[CTRL_FLUSH_BIT];
    assign rd_hit  = data_rd | stat_rd;

    assign pop_req = (state_q == ST_IDLE) & ~fifo_empty & ~tx_busy & ~flush;
    assign ovf_set = data_wr & fifo_full & ~pop_req & ~flush;

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset_ (reset_),
        .push   (data_wr),
        .pop    (pop_req),
        .flush  (flush),
        .din    (m_wr_data),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign count_ext = 5'(fifo_count);
    assign free_cnt  = 8'(FIFO_DEPTH) - 8'(fifo_count);

    always_comb begin
        status                        = '0;
        status[STAT_CNT_LSB +: 4]     = count_ext[3:0];
        status[STAT_OVF_BIT]          = ovf_q;
        status[STAT_TOERR_BIT]        = toerr_q;
        status[STAT_ACTIVE_BIT]       = (state_q != ST_IDLE);
        status[STAT_FULL_BIT]         = fifo_full;
        rd_data = '0;
        if (stat_rd)      rd_data = status;
        else if (data_rd) rd_data = free_cnt;
    end

    // Transmitter handshake: tx_wr_en pulses for one cycle per byte; the
    // transmitter acknowledges by raising tx_busy and signals done by lowering it.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        tx_din_d = tx_din_q;
        to_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_req) begin
                    tx_din_d = fifo_dout;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tmr_d   = '0;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmr_q == TMR_LAST) begin
                    to_set  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky flags: a set event beats the clear-on-read in the same cycle.
    assign ovf_d   = ovf_set | (ovf_q & ~stat_rd);
    assign toerr_d = to_set  | (toerr_q & ~stat_rd);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            tx_din_q <= '0;
            ovf_q    <= 1'b0;
            toerr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            tx_din_q <= tx_din_d;
            ovf_q    <= ovf_d;
            toerr_q  <= toerr_d;
        end
    end

    assign tx_wr_en  = (state_q == ST_LAUNCH);
    assign tx_din    = tx_din_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a scoreboard on launched bytes and reads.
module tb_uart_tx_ctrl;
    import soc_mmio_pkg::*;

    localparam logic [10:0] A_DATA = UART_DATA_ADDR;
    localparam logic [10:0] A_STAT = UART_STAT_ADDR;

    logic        clk = 1'b0;
    logic        reset_;
    logic [10:0] m_addr;
    logic [7:0]  m_wr_data;
    logic        m_wr, m_rd, m_en;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic [7:0]  tx_din;
    logic        tx_wr_en;
    logic        tx_busy;
    logic [1:0]  dbg_state;

    logic        man_busy;
    logic        auto_tx;
    logic        model_busy = 1'b0;
    logic [2:0]  bsy_cnt = 3'd0;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_launch = 0;
    int          last_launch_cyc = 0;
    int          prev_launch_cyc = 0;
    int          wr_cyc;
    int          base;

    logic [7:0]  exp_tx_q[$];
    logic [7:0]  exp_rd_q[$];

    uart_tx_ctrl dut (
        .clk       (clk),
        .reset_    (reset_),
        .m_addr    (m_addr),
        .m_wr_data (m_wr_data),
        .m_wr      (m_wr),
        .m_rd      (m_rd),
        .m_en      (m_en),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .tx_din    (tx_din),
        .tx_wr_en  (tx_wr_en),
        .tx_busy   (tx_busy),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy rises the cycle after a launch and holds a few cycles.
    assign tx_busy = auto_tx ? model_busy : man_busy;
    always @(posedge clk) begin
        if (!auto_tx || !reset_) begin
            model_busy <= 1'b0;
            bsy_cnt    <= 3'd0;
        end else if (tx_wr_en) begin
            model_busy <= 1'b1;
            bsy_cnt    <= 3'd4;
        end else if (bsy_cnt != 3'd0) begin
            bsy_cnt    <= bsy_cnt - 3'd1;
        end else begin
            model_busy <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Driver tasks: called at posedge+1, drive one bus cycle, return at next posedge+1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [10:0] a, input logic [7:0] d);
        m_en = 1'b1; m_wr = 1'b1; m_rd = 1'b0; m_addr = a; m_wr_data = d;
        step();
        m_en = 1'b0; m_wr = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        exp_tx_q.push_back(d);
        bus_write(A_DATA, d);
    endtask

    task automatic bus_read(input logic [10:0] a, input logic [7:0] exp);
        exp_rd_q.push_back(exp);
        m_en = 1'b1; m_rd = 1'b1; m_wr = 1'b0; m_addr = a;
        step();
        m_en = 1'b0; m_rd = 1'b0;
    endtask

    task automatic wait_launches(input int target, input int budget);
        int k = 0;
        while (n_launch < target && k < budget) begin
            step();
            k++;
        end
        check("launch_count", n_launch, target);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (dbg_state != ST_IDLE && k < budget) begin
            step();
            k++;
        end
        check("reach_idle", dbg_state, ST_IDLE);
    endtask

    initial begin
        reset_ = 1'b0; m_en = 1'b0; m_wr = 1'b0; m_rd = 1'b0;
        m_addr = '0; m_wr_data = '0; man_busy = 1'b0; auto_tx = 1'b0;

        // Scoreboard monitor
        fork
            forever begin
                @(negedge clk);
                if (reset_ && tx_wr_en) begin
                    n_launch++;
                    prev_launch_cyc = last_launch_cyc;
                    last_launch_cyc = cyc;
                    if (exp_tx_q.size() == 0) fail_evt("unexpected_launch", tx_din);
                    else check("tx_din", tx_din, exp_tx_q.pop_front());
                end
                if (reset_ && rd_hit) begin
                    if (exp_rd_q.size() == 0) fail_evt("unexpected_read", rd_data);
                    else check("rd_data", rd_data, exp_rd_q.pop_front());
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_wr_en", tx_wr_en, 0);
        check("rst_tx_din", tx_din, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_rd_hit", rd_hit, 0);
        reset_ = 1'b1;
        step();
        bus_read(A_STAT, 8'h00);
        bus_read(A_DATA, 8'h08);

        m_en = 1'b1; m_rd = 1'b1; m_addr = LED_ADDR;
        #3;
        check("miss_hit", rd_hit, 0);
        check("miss_data", rd_data, 0);
        step();
        m_en = 1'b0; m_rd = 1'b0;

        // Single byte, two-cycle launch latency
        wr_cyc = cyc;
        push_byte(8'h41);
        repeat (4) step();
        man_busy = 1'b1;
        check("t1_launches", n_launch, 1);
        check("t1_latency", last_launch_cyc - wr_cyc, 2);
        repeat (10) step();
        check("t1_wait_done", dbg_state, ST_WAIT_DONE);
        bus_read(A_STAT, 8'h02);
        repeat (9) step();
        man_busy = 1'b0;
        step();
        check("t1_idle", dbg_state, ST_IDLE);

        // Fill past full while busy, then push-with-pop at full
        man_busy = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
        bus_write(A_DATA, 8'h18);
        bus_read(A_STAT, 8'h89);
        bus_read(A_STAT, 8'h81);
        bus_read(A_DATA, 8'h00);
        man_busy = 1'b0;
        push_byte(8'h19);
        auto_tx = 1'b1;
        bus_read(A_STAT, 8'h83);
        wait_launches(10, 200);
        wait_idle(30);
        auto_tx = 1'b0;
        bus_read(A_STAT, 8'h00);

        // Start timeout with busy stuck low
        man_busy = 1'b0;
        base = n_launch;
        push_byte(8'hA1);
        push_byte(8'hA2);
        wait_launches(base + 2, 100);
        check("t3_timeout_gap", last_launch_cyc - prev_launch_cyc, 17);
        repeat (20) step();
        bus_read(A_STAT, 8'h04);
        bus_read(A_STAT, 8'h00);

        // Flush while a frame is in WAIT_DONE
        base = n_launch;
        push_byte(8'hC1);
        bus_write(A_DATA, 8'hC2);
        bus_write(A_DATA, 8'hC3);
        man_busy = 1'b1;
        step();
        check("t4_wait_done", dbg_state, ST_WAIT_DONE);
        bus_write(A_STAT, 8'h01);
        bus_read(A_STAT, 8'h02);
        repeat (5) step();
        man_busy = 1'b0;
        repeat (10) step();
        check("t4_launches", n_launch, base + 1);
        bus_read(A_STAT, 8'h00);
        bus_read(A_DATA, 8'h08);

        // Reset mid-frame with four bytes queued
        base = n_launch;
        push_byte(8'hD1);
        for (int i = 2; i <= 5; i++) bus_write(A_DATA, 8'(8'hD0 + i));
        man_busy = 1'b1;
        step();
        check("t5_wait_done", dbg_state, ST_WAIT_DONE);
        bus_read(A_STAT, 8'h42);
        #3;
        reset_ = 1'b0;
        #1;
        check("t5_rst_wr_en", tx_wr_en, 0);
        check("t5_rst_tx_din", tx_din, 0);
        check("t5_rst_state", dbg_state, ST_IDLE);
        man_busy = 1'b0;
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        step();
        repeat (10) step();
        check("t5_no_launch", n_launch, base + 1);
        bus_read(A_STAT, 8'h00);
        bus_read(A_DATA, 8'h08);

        repeat (2) step();
        check("exp_tx_drained", exp_tx_q.size(), 0);
        check("exp_rd_drained", exp_rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
